// File: rtl/ysyx_24090003_pkg.sv
// Shared types and constants for the ysyx_24090003 core: the WBU state encoding
// and the RV32 load funct3 codes.
package ysyx_24090003_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_24090003_load_ext.sv
// Combinational load extender: picks the addressed byte/half from an aligned
// memory word and sign- or zero-extends it according to the load funct3.
module ysyx_24090003_load_ext
  import ysyx_24090003_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lanes[addr_lo];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (fmt)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LBU:     result = {24'd0, byte_sel};
      LHU:     result = {16'd0, half_sel};
      LW:      result = rdata;
      default: result = rdata;  // undefined encodings pass the whole word
    endcase
  end

endmodule

// File: rtl/ysyx_24090003_wbu.sv
// Writeback unit: accepts one retired instruction, waits for load data if needed,
// then strobes the register file for one cycle. Optional minstret via YSYX_24090003_WBU_MINSTRET_EN.
module ysyx_24090003_wbu
  import ysyx_24090003_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_load_fmt,
  input  logic [1:0]  ex_addr_lo,
  input  logic [31:0] ex_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        reg_write_enable,
  output logic [4:0]  EXrd,
  output logic [31:0] reg_write_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        commit,
  output logic [63:0] minstret
);

  wbu_state_e  state_reg;
  logic [4:0]  pend_rd_reg;
  logic        pend_wen_reg;
  logic [2:0]  pend_fmt_reg;
  logic [1:0]  pend_addr_reg;
  logic        wen_reg;
  logic [4:0]  exrd_reg;
  logic [31:0] wdata_reg;
  logic        commit_reg;
  logic [31:0] load_data;
  logic        pend_write;

  ysyx_24090003_load_ext u_load_ext (
    .fmt     (pend_fmt_reg),
    .addr_lo (pend_addr_reg),
    .rdata   (mem_rdata),
    .result  (load_data)
  );

  // The write-port outputs are loaded on the transition into WRITE and cleared
  // on leaving it, so they never see ex_* combinationally.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pend_rd_reg   <= '0;
      pend_wen_reg  <= 1'b0;
      pend_fmt_reg  <= '0;
      pend_addr_reg <= '0;
      wen_reg       <= 1'b0;
      exrd_reg      <= '0;
      wdata_reg     <= '0;
      commit_reg    <= 1'b0;
    end else begin
      wen_reg    <= 1'b0;
      commit_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            pend_rd_reg   <= ex_rd;
            pend_wen_reg  <= ex_wen;
            pend_fmt_reg  <= ex_load_fmt;
            pend_addr_reg <= ex_addr_lo;
            if (ex_is_load) begin
              state_reg <= WAIT_MEM;
            end else begin
              state_reg  <= WRITE;
              wen_reg    <= ex_wen && (ex_rd != 5'd0);
              exrd_reg   <= ex_rd;
              wdata_reg  <= ex_result;
              commit_reg <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            state_reg  <= WRITE;
            wen_reg    <= pend_wen_reg && (pend_rd_reg != 5'd0);
            exrd_reg   <= pend_rd_reg;
            wdata_reg  <= load_data;
            commit_reg <= 1'b1;
          end
        end
        WRITE:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pend_write       = (state_reg != IDLE) && pend_wen_reg && (pend_rd_reg != 5'd0);
  assign hazard           = pend_write && ((rs1 == pend_rd_reg) || (rs2 == pend_rd_reg));
  assign ex_ready         = (state_reg == IDLE);
  assign reg_write_enable = wen_reg;
  assign EXrd             = exrd_reg;
  assign reg_write_data   = wdata_reg;
  assign commit           = commit_reg;

`ifdef YSYX_24090003_WBU_MINSTRET_EN
  logic [63:0] minstret_reg;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      minstret_reg <= '0;
    end else if (commit_reg) begin
      minstret_reg <= minstret_reg + 64'd1;
    end
  end

  assign minstret = minstret_reg;
`else
  assign minstret = '0;
`endif

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Self-checking bench for ysyx_24090003_wbu: directed cases from the test plan
// followed by randomized transactions checked against a behavioural model.
module tb_ysyx_24090003_wbu;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic        ex_wen = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [2:0]  ex_load_fmt = '0;
  logic [1:0]  ex_addr_lo = '0;
  logic [31:0] ex_result = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        reg_write_enable;
  logic [4:0]  EXrd;
  logic [31:0] reg_write_data;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard;
  logic        commit;
  logic [63:0] minstret;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint unsigned commits = 0;

  ysyx_24090003_wbu dut (
    .cpu_clk          (cpu_clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_rd            (ex_rd),
    .ex_wen           (ex_wen),
    .ex_is_load       (ex_is_load),
    .ex_load_fmt      (ex_load_fmt),
    .ex_addr_lo       (ex_addr_lo),
    .ex_result        (ex_result),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .reg_write_enable (reg_write_enable),
    .EXrd             (EXrd),
    .reg_write_data   (reg_write_data),
    .rs1              (rs1),
    .rs2              (rs2),
    .hazard           (hazard),
    .commit           (commit),
    .minstret         (minstret)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [63:0] exp_minstret();
`ifdef YSYX_24090003_WBU_MINSTRET_EN
    return commits;
`else
    return 64'd0;
`endif
  endfunction

  // Reference load extension from arithmetic on the word, not bit slicing.
  function automatic logic [31:0] ref_load(input logic [2:0] fmt, input logic [1:0] a,
                                           input logic [31:0] w);
    int unsigned b, h, sh;
    sh = 8 * int'(a);
    b  = (w >> sh) & 32'hFF;
    h  = (w >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
    case (fmt)
      3'b000:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // One complete instruction: accept, optional memory wait, write, back to idle.
  task automatic run_txn(input bit is_load, input logic [2:0] fmt, input logic [1:0] addr,
                         input logic [4:0] rd, input bit wen, input logic [31:0] result,
                         input logic [31:0] rdata, input logic [31:0] exp_data, input int lat);
    logic [4:0] r1, r2;
    bit exp_we;
    exp_we = wen && (rd != 5'd0);
    ex_valid = 1'b1; ex_rd = rd; ex_wen = wen; ex_is_load = is_load;
    ex_load_fmt = fmt; ex_addr_lo = addr; ex_result = result;
    mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;  // must be ignored at acceptance
    rs1 = rd; rs2 = rd;
    #1;
    chk("ready_idle", ex_ready, 1);
    chk("hazard_idle", hazard, 0);
    tick();
    ex_valid = 1'b0; ex_rd = 5'($urandom); ex_wen = 1'($urandom); ex_is_load = 1'($urandom);
    ex_load_fmt = 3'($urandom); ex_addr_lo = 2'($urandom); ex_result = $urandom;
    mem_rvalid = 1'b0;
    if (is_load) begin
      for (int i = 0; i <= lat; i++) begin
        r1 = ($urandom % 2) ? rd : 5'($urandom);
        r2 = ($urandom % 2) ? rd : 5'($urandom);
        rs1 = r1; rs2 = r2;
        mem_rvalid = (i == lat);
        mem_rdata  = (i == lat) ? rdata : $urandom;
        #1;
        chk("wait_hazard", hazard, wen && (rd != 0) && (r1 == rd || r2 == rd));
        chk("wait_no_we", reg_write_enable, 0);
        chk("wait_ready", ex_ready, 0);
        tick();
      end
      mem_rdata = $urandom;
    end
    mem_rvalid = 1'($urandom % 2);
    rs1 = rd; rs2 = 5'($urandom);
    #1;
    chk("write_we", reg_write_enable, exp_we);
    chk("write_commit", commit, 1);
    chk("write_ready", ex_ready, 0);
    chk("write_hazard", hazard, exp_we);
    if (wen) chk("write_rd", EXrd, rd);
    if (exp_we) chk("write_data", reg_write_data, exp_data);
    $display("txn load=%0d fmt=%0d addr=%0d rd=%0d wen=%0d we=%0d data=0x%08h exp=0x%08h",
             is_load, fmt, addr, rd, wen, reg_write_enable, reg_write_data, exp_data);
    commits++;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("after_commit", commit, 0);
    chk("after_we", reg_write_enable, 0);
    chk("after_ready", ex_ready, 1);
    chk("after_hazard", hazard, 0);
    chk("minstret", minstret, exp_minstret());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w, res;
    logic [2:0]  fmt;
    logic [1:0]  a;
    logic [4:0]  rd;
    bit          ld, wen;

    // Reset values
    repeat (3) tick();
    rs1 = 5'd3; rs2 = 5'd0;
    #1;
    chk("rst_ready", ex_ready, 1);
    chk("rst_we", reg_write_enable, 0);
    chk("rst_exrd", EXrd, 0);
    chk("rst_data", reg_write_data, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_commit", commit, 0);
    chk("rst_minstret", minstret, 0);
    rst = 1'b0;
    tick();

    // Directed: non-load, x0 suppression, load extension cases
    run_txn(0, 3'b000, 2'd0, 5'd5, 1, 32'h1234_5678, 32'h0, 32'h1234_5678, 0);
    run_txn(0, 3'b000, 2'd0, 5'd0, 1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn(1, 3'b000, 2'd2, 5'd10, 1, 32'h0, 32'h80FF_7F01, 32'hFFFF_FFFF, 1);
    run_txn(1, 3'b100, 2'd3, 5'd11, 1, 32'h0, 32'h80FF_7F01, 32'h0000_0080, 0);
    run_txn(1, 3'b001, 2'd2, 5'd12, 1, 32'h0, 32'h80FF_7F01, 32'hFFFF_80FF, 2);
    run_txn(1, 3'b101, 2'd0, 5'd13, 1, 32'h0, 32'h80FF_7F01, 32'h0000_7F01, 3);

    // Directed: hazard while a load to x7 waits four cycles
    ex_valid = 1'b1; ex_rd = 5'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
    ex_load_fmt = 3'b010; ex_addr_lo = 2'd0;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs1 = 5'd7; rs2 = 5'd0; #1;
      chk("haz_rs1_match", hazard, 1);
      rs1 = 5'd0; rs2 = 5'd8; #1;
      chk("haz_no_match", hazard, 0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("haz_write_we", reg_write_enable, 1);
    chk("haz_write_data", reg_write_data, 32'hCAFE_F00D);
    commits++;
    tick();
    rs1 = 5'd7; #1;
    chk("haz_after_write", hazard, 0);
    $display("txn hazard-load rd=7 done hazard=%0d", hazard);

    // Directed: reset during WAIT_MEM drops the instruction
    ex_valid = 1'b1; ex_rd = 5'd9; ex_wen = 1'b1; ex_is_load = 1'b1; ex_load_fmt = 3'b010;
    tick();
    ex_valid = 1'b0;
    tick();
    rst = 1'b1; rs1 = 5'd9;
    #1;
    chk("midrst_we", reg_write_enable, 0);
    chk("midrst_hazard", hazard, 0);
    chk("midrst_ready", ex_ready, 1);
    chk("midrst_commit", commit, 0);
    tick();
    rst = 1'b0;
    commits = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_we", reg_write_enable, 0);
    chk("late_rvalid_commit", commit, 0);
    chk("late_rvalid_ready", ex_ready, 1);
    tick();
    chk("late_rvalid_we2", reg_write_enable, 0);
    chk("late_rvalid_minstret", minstret, 0);
    $display("txn reset-in-wait dropped ready=%0d", ex_ready);

    // Counter: ten back-to-back instructions
    for (int i = 0; i < 10; i++) begin
      res = $urandom;
      run_txn(0, 3'b000, 2'd0, 5'(i + 1), 1, res, 32'h0, res, 0);
    end
`ifdef YSYX_24090003_WBU_MINSTRET_EN
    chk("minstret_ten", minstret, 64'd10);
`else
    chk("minstret_ten", minstret, 64'd0);
`endif

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      ld  = 1'($urandom % 2);
      fmt = 3'($urandom);
      a   = 2'($urandom);
      rd  = 5'($urandom);
      wen = ($urandom % 4) != 0;
      w   = $urandom;
      res = $urandom;
      run_txn(ld, fmt, a, rd, wen, res, w, ld ? ref_load(fmt, a, w) : res, int'($urandom % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_wbu.md
# ysyx_24090003_wbu

Writeback unit for the single-issue ysyx_24090003 core. It accepts one completed instruction at a time from the EXU over a valid/ready handshake. For loads it waits for memory read data, then byte/half-selects and extends it. It drives the register file write port (reg_write_enable / EXrd / reg_write_data) for exactly one cycle per instruction, and tells the IDU whether a source register has a write still pending.

## Interface
Parameters:
- none; all widths are fixed by the RV32 ISA (XLEN 32, 5-bit register index).

Ports:
- cpu_clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EXU presents a completed instruction.
- ex_ready  out  1  WBU can accept; high only in IDLE.
- ex_rd  in  5  destination register index.
- ex_wen  in  1  instruction writes rd.
- ex_is_load  in  1  result comes from memory rather than ex_result.
- ex_load_fmt  in  3  funct3 of the load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- ex_addr_lo  in  2  load address bits [1:0].
- ex_result  in  32  ALU/CSR result for non-loads.
- mem_rvalid  in  1  memory read data valid; single-cycle pulse.
- mem_rdata  in  32  aligned memory word.
- reg_write_enable  out  1  register file write strobe.
- EXrd  out  5  register file write index.
- reg_write_data  out  32  register file write data.
- rs1, rs2  in  5  IDU source indices for the hazard check.
- hazard  out  1  rs1 or rs2 matches a pending nonzero write.
- commit  out  1  one-cycle pulse per retired instruction.
- minstret  out  64  retired-instruction count; see Configuration.

## Operation
States:
- IDLE: ex_ready=1.
  - On ex_valid, latch rd, wen, is_load, fmt, addr_lo and result.
  - Go to WAIT_MEM if is_load, else WRITE.
- WAIT_MEM: wait for mem_rvalid.
  - On mem_rvalid, latch the extended load data and go to WRITE.
  - mem_rdata is ignored in every other state.
- WRITE: assert commit=1 for this one cycle.
  - reg_write_enable = pend_wen && pend_rd!=0.
  - Go to IDLE.

Rules:
- x0 is never written. The register file does not hardwire x0, so the WBU must suppress the strobe when rd is 0.
- Load extension:
  - Byte = rdata[8*addr_lo +: 8].
  - Half = addr_lo[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw and any undefined fmt pass the full word.
- hazard = (state!=IDLE) && pend_wen && pend_rd!=0 && (rs1==pend_rd || rs2==pend_rd). It is combinational from rs1/rs2.
- reg_write_enable, EXrd, reg_write_data and commit are registered state-derived outputs. They must not be combinational from ex_* inputs.

## Timing
- Non-load: accepted at edge N; write strobe and commit are asserted in cycle N+1; ex_ready returns high in cycle N+2. Throughput is one instruction per 2 cycles.
- Load: accepted at edge N; mem_rvalid at edge M; write in cycle M+1.
- mem_rvalid in the same cycle as acceptance is ignored. Memory responds at the earliest one cycle after acceptance.
- Reset values: state IDLE, ex_ready=1, reg_write_enable=0, EXrd=0, reg_write_data=0, hazard=0, commit=0, minstret=0.
- Reset asserted mid-operation drops the pending instruction with no write and no commit.
- An instruction with ex_wen=0 still passes through WRITE and commits, with the strobe low.

## Configuration
- YSYX_24090003_WBU_MINSTRET_EN defined: minstret is a 64-bit counter that increments on every commit, with carry across bit 31.
- Macro undefined: minstret is tied to 0 and no counter flops are generated.

## Structure
- Shared package ysyx_24090003_pkg holds:
  - the WBU state enum (IDLE, WAIT_MEM, WRITE);
  - load funct3 constants LB/LH/LW/LBU/LHU.
- One sub-module, ysyx_24090003_load_ext: a purely combinational extender taking (fmt, addr_lo, rdata) and returning the 32-bit result.

## Test plan
- Non-load: ex_rd=5, ex_wen=1, ex_result=0x12345678 -> one cycle later reg_write_enable=1, EXrd=5, data 0x12345678, commit=1; ex_ready low for exactly 1 cycle.
- x0 suppression: ex_rd=0, ex_wen=1 -> reg_write_enable stays 0; commit still pulses.
- Load extension: mem_rdata=0x80FF7F01.
  - lb, addr_lo=2 -> 0xFFFFFFFF.
  - lbu, addr_lo=3 -> 0x00000080.
  - lh, addr_lo=2 -> 0xFFFF80FF.
  - lhu, addr_lo=0 -> 0x00007F01.
- Hazard: load to rd=7 held in WAIT_MEM for 4 cycles.
  - rs1=7 -> hazard=1 throughout.
  - rs2=8, rs1=0 -> hazard=0.
  - After WRITE, hazard=0.
- Reset: assert rst while in WAIT_MEM, then release.
  - No write occurs; hazard=0; ex_ready=1.
  - A late mem_rvalid is ignored.
- Counter: 10 back-to-back instructions.
  - With the macro: minstret=10.
  - Without the macro: minstret=0.
